// File: rtl/pipe_ctl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctl_pkg
// Shared definitions for the mips789 pipeline sequencer. pc_gen decodes the
// same PC_* select codes, so any change here must be mirrored there.
//   PC_IGN : normal sequential fetch
//   PC_KEP : hold the current PC
//   PC_IRQ : jump to the interrupt vector
//   PC_RST : force the reset vector (PC 0)
// State encodings of the pipe_ctl sequencer are also defined here.
// Optional build macro used by the users of this package: PIPE_PERF_CNT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package pipe_ctl_pkg;

    localparam logic [3:0] PC_IGN = 4'd1;
    localparam logic [3:0] PC_KEP = 4'd2;
    localparam logic [3:0] PC_IRQ = 4'd4;
    localparam logic [3:0] PC_RST = 4'd8;

    typedef enum logic [2:0] {
        S_RST       = 3'd0,
        S_RUN       = 3'd1,
        S_STALL     = 3'd2,
        S_IRQ_JMP   = 3'd3,
        S_IRQ_FLUSH = 3'd4
    } state_e;

    // A cycle-stretching request from either multi-cycle source.
    function automatic logic is_busy(input logic mem_wait, input logic muldiv_busy);
        return mem_wait | muldiv_busy;
    endfunction

endpackage

// File: rtl/pipe_ctl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctl_if
// Bundle between the pipeline sequencer and the rest of the core.
//   Requests into the sequencer : irq_req, irq_en, ret_i, muldiv_busy,
//                                 mem_wait, load_use
//   Controls out of the sequencer: pc_prectl[3:0], pause, rd_clk_cls, flush,
//                                 zz_spc_we, irq_ack, in_isr
//   stall_cnt[31:0] exists only when PIPE_PERF_CNT_EN is defined.
// Modports:
//   master : the core side (decoder, memories, mul/div, interrupt source)
//   slave  : pipe_ctl itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface pipe_ctl_if;

    logic       irq_req;
    logic       irq_en;
    logic       ret_i;
    logic       muldiv_busy;
    logic       mem_wait;
    logic       load_use;
    logic [3:0] pc_prectl;
    logic       pause;
    logic       rd_clk_cls;
    logic       flush;
    logic       zz_spc_we;
    logic       irq_ack;
    logic       in_isr;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    modport master (
`ifdef PIPE_PERF_CNT_EN
        input  stall_cnt,
`endif
        output irq_req, irq_en, ret_i, muldiv_busy, mem_wait, load_use,
        input  pc_prectl, pause, rd_clk_cls, flush, zz_spc_we, irq_ack, in_isr
    );

    modport slave (
`ifdef PIPE_PERF_CNT_EN
        output stall_cnt,
`endif
        input  irq_req, irq_en, ret_i, muldiv_busy, mem_wait, load_use,
        output pc_prectl, pause, rd_clk_cls, flush, zz_spc_we, irq_ack, in_isr
    );

endinterface

// File: rtl/pipe_ctl_cnt.sv
// ---------------------------------------------------------------------------
// pipe_cnt
// Loadable down-counter with enable and zero flag. Used by pipe_ctl for both
// the reset hold-off and the post-interrupt flush length. It saturates at 0.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset, loads RST_VAL
//   i_load     : load i_load_val (wins over i_en)
//   i_load_val : value to load
//   i_en       : count down by one when non-zero
//   o_zero     : counter is zero
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pipe_cnt #(
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Counter register: async reset to RST_VAL, load has priority over count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != {W{1'b0}})) begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/pipe_ctl.sv
// ---------------------------------------------------------------------------
// pipe_ctl
// Central pipeline sequencer of the mips789 core: reset hold-off, multi-cycle
// stalls, load-use bubbles and interrupt entry/return.
// Ports:
//   clk : core clock, rising edge
//   rst : asynchronous active-low reset
//   bus : pipe_ctl_if.slave (requests in, pc_prectl/pause/rd_clk_cls/flush/
//         zz_spc_we/irq_ack/in_isr out)
// Parameters:
//   RST_CYC   : cycles PC_RST is held after rst deasserts (>=1)
//   FLUSH_CYC : flush cycles after the IRQ vector jump (>=1)
//   CNT_W     : counter width, must hold max(RST_CYC, FLUSH_CYC)
// Build option: PIPE_PERF_CNT_EN adds bus.stall_cnt, a wrapping 32-bit count
// of paused or load-use bubble cycles outside reset.
// Outputs are decoded from the registered state; in S_RUN and S_IRQ_FLUSH the
// decode also looks at the current requests so a stall or bubble takes effect
// in the very cycle it is raised.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pipe_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int RST_CYC   = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctl_if.slave   bus
);

    localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYC - 1);

    state_e     r_state;
    logic       r_in_isr;

    logic       w_busy;
    logic       w_irq_take;
    logic       w_cnt_zero;
    logic       w_cnt_load;
    logic       w_cnt_en;
    logic [3:0] w_pc_prectl;
    logic       w_pause;
    logic       w_rd_clk_cls;
    logic       w_flush;
    logic       w_zz_spc_we;
    logic       w_irq_ack;

    assign w_busy     = is_busy(bus.mem_wait, bus.muldiv_busy);
    // in_isr masks nesting; ERET clears it at the edge, so an irq raised with
    // ERET is only seen as takeable one cycle later.
    assign w_irq_take = bus.irq_req & bus.irq_en & ~r_in_isr;

    // The flush count freezes while memory is not ready.
    assign w_cnt_load = (r_state == S_IRQ_JMP);
    assign w_cnt_en   = (r_state == S_RST) |
                        ((r_state == S_IRQ_FLUSH) & ~bus.mem_wait);

    pipe_cnt #(
        .W       (CNT_W),
        .RST_VAL (RST_LD)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (FLUSH_LD),
        .i_en       (w_cnt_en),
        .o_zero     (w_cnt_zero)
    );

    // Sequencer state and interrupt-active flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_RST;
            r_in_isr <= 1'b0;
        end else begin
            case (r_state)
                S_RST: begin
                    if (w_cnt_zero) begin
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_RST;
                    end
                end
                S_RUN: begin
                    if (w_busy) begin
                        r_state <= S_STALL;
                    end else if (w_irq_take) begin
                        r_state <= S_IRQ_JMP;
                    end else begin
                        r_state <= S_RUN;
                    end
                    if (bus.ret_i) begin
                        r_in_isr <= 1'b0;
                    end else begin
                        r_in_isr <= r_in_isr;
                    end
                end
                S_STALL: begin
                    if (w_busy) begin
                        r_state <= S_STALL;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_IRQ_JMP: begin
                    r_state  <= S_IRQ_FLUSH;
                    r_in_isr <= 1'b1;
                end
                S_IRQ_FLUSH: begin
                    if (w_cnt_zero && !bus.mem_wait) begin
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IRQ_FLUSH;
                    end
                end
                default: begin
                    r_state  <= S_RST;
                    r_in_isr <= 1'b0;
                end
            endcase
        end
    end

    // Control decode from the registered state (plus same-cycle requests).
    always_comb begin
        w_pc_prectl  = PC_IGN;
        w_pause      = 1'b0;
        w_rd_clk_cls = 1'b0;
        w_flush      = 1'b0;
        w_zz_spc_we  = 1'b0;
        w_irq_ack    = 1'b0;
        case (r_state)
            S_RST: begin
                w_pc_prectl = PC_RST;
                w_pause     = 1'b1;
                w_flush     = 1'b1;
            end
            S_RUN: begin
                if (w_busy) begin
                    w_pc_prectl = PC_KEP;
                    w_pause     = 1'b1;
                end else if (w_irq_take) begin
                    w_pc_prectl = PC_IGN;
                end else if (bus.load_use) begin
                    // one-cycle bubble: hold PC and read address, kill ID->EX
                    w_pc_prectl  = PC_KEP;
                    w_rd_clk_cls = 1'b1;
                    w_flush      = 1'b1;
                end else begin
                    w_pc_prectl = PC_IGN;
                end
            end
            S_STALL: begin
                w_pc_prectl = PC_KEP;
                w_pause     = 1'b1;
            end
            S_IRQ_JMP: begin
                w_pc_prectl = PC_IRQ;
                w_zz_spc_we = 1'b1;
                w_irq_ack   = 1'b1;
                w_flush     = 1'b1;
            end
            S_IRQ_FLUSH: begin
                w_pc_prectl = PC_IGN;
                w_flush     = 1'b1;
                if (bus.mem_wait) begin
                    w_pause = 1'b1;
                end else begin
                    w_pause = 1'b0;
                end
            end
            default: begin
                w_pc_prectl = PC_RST;
                w_pause     = 1'b1;
                w_flush     = 1'b1;
            end
        endcase
    end

    assign bus.pc_prectl  = w_pc_prectl;
    assign bus.pause      = w_pause;
    assign bus.rd_clk_cls = w_rd_clk_cls;
    assign bus.flush      = w_flush;
    assign bus.zz_spc_we  = w_zz_spc_we;
    assign bus.irq_ack    = w_irq_ack;
    assign bus.in_isr     = r_in_isr;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    // Lost-cycle counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state != S_RST) && (w_pause || w_rd_clk_cls)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
